// File: rtl/ex_alu_stage_pkg.sv
// ALU control encodings and the EX/MEM entry layout shared by the execute stage.
// Codes must track the decode-side ALU control exactly.
package alu_pkg;
  localparam int ALU_W = 32;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SUBU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_NOR  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_SLL  = 5'd10;
  localparam logic [4:0] ALU_SRL  = 5'd11;
  localparam logic [4:0] ALU_SRA  = 5'd12;
  localparam logic [4:0] ALU_SLC  = 5'd13;
  localparam logic [4:0] ALU_LUI  = 5'd14;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic [4:0]       rd;
    logic             wreg;
    logic             ovf;
  } ex_entry_t;
endpackage

// File: rtl/ex_alu_stage_if.sv
// ID/EX request side and EX/MEM response side of the execute stage.
// The stage itself connects through the slave modport.
interface ex_alu_stage_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_aluc;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [4:0]        in_rd;
  logic              in_wreg;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [4:0]        out_rd;
  logic              out_wreg;
  logic              out_ovf;
  logic              out_zero;

  modport slave (
    input  in_valid, in_aluc, in_a, in_b, in_rd, in_wreg, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wreg, out_ovf, out_zero
  );

  modport master (
    output in_valid, in_aluc, in_a, in_b, in_rd, in_wreg, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wreg, out_ovf, out_zero
  );
endinterface

// File: rtl/ex_alu_stage_core.sv
// Combinational ALU: result and signed-overflow flag from a, b and aluc.
// For shifts, a carries the shift amount and b the value being shifted.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        aluc,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);
  localparam int SA_W = $clog2(DATA_W);

  logic [SA_W-1:0]     sa;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [2*DATA_W-1:0] rot;

  assign sa   = a[SA_W-1:0];
  assign sum  = a + b;
  assign diff = a - b;
  // Rotate left: the upper half of {b,b} shifted left holds b rotated by sa.
  assign rot  = {b, b} << sa;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (aluc)
      ALU_ADD: begin
        result = sum;
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_ADDU: result = sum;
      ALU_SUB: begin
        result = diff;
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUBU: result = diff;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLL:  result = b << sa;
      ALU_SRL:  result = b >> sa;
      ALU_SRA:  result = $signed(b) >>> sa;
      ALU_SLC:  result = rot[2*DATA_W-1:DATA_W];
      ALU_LUI:  result = b << 16;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/ex_alu_stage.sv
// Registered execute stage: ALU result held in EX/MEM register M with a one-entry skid S.
// in_ready is a pure register output (!S valid), so a MEM stall never reaches ID combinationally.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ex_alu_stage_if.slave        bus
);
  ex_entry_t         m_q, s_q, new_entry;
  logic              m_vld, s_vld;
  logic              accept, issue;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .a      (bus.in_a),
    .b      (bus.in_b),
    .aluc   (bus.in_aluc),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  // A trapping op still records its result but must not write back.
  assign new_entry = '{result: alu_result, rd: bus.in_rd,
                       wreg: bus.in_wreg & ~alu_ovf, ovf: alu_ovf};

  assign accept = bus.in_valid && !s_vld;
  assign issue  = m_vld && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else if (bus.flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (issue && s_vld) begin
      m_q   <= s_q;
      s_vld <= 1'b0;
    end else if (accept && (!m_vld || issue)) begin
      m_q   <= new_entry;
      m_vld <= 1'b1;
    end else if (accept) begin
      s_q   <= new_entry;
      s_vld <= 1'b1;
    end else if (issue) begin
      m_vld <= 1'b0;
    end
  end

  assign bus.in_ready   = !s_vld;
  assign bus.out_valid  = m_vld;
  assign bus.out_result = m_q.result;
  assign bus.out_rd     = m_q.rd;
  assign bus.out_wreg   = m_q.wreg;
  assign bus.out_ovf    = m_q.ovf;
  assign bus.out_zero   = (m_q.result == '0);
endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed vectors with a scoreboard queue; a negedge monitor checks every EX/MEM issue.
module tb_ex_alu_stage;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wreg;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];

  ex_alu_stage_if #(.DATA_W(32)) bus();
  ex_alu_stage #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: the issue handshake completes at the next posedge, so sample at negedge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_issue actual=%h rd=%0d expected=none", bus.out_result, bus.out_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.out_result, e.res);
        chk("rd",     {27'd0, bus.out_rd}, {27'd0, e.rd});
        chk("wreg",   {31'd0, bus.out_wreg}, {31'd0, e.wreg});
        chk("ovf",    {31'd0, bus.out_ovf}, {31'd0, e.ovf});
        chk("zero",   {31'd0, bus.out_zero}, {31'd0, (e.res == 32'd0)});
      end
    end
  end

  task automatic send(input logic [4:0] aluc, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic wreg,
                      input logic [31:0] exp_res, input logic exp_ovf);
    exp_t e;
    bit   ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_aluc  = aluc;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_rd    = rd;
    bus.in_wreg  = wreg;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      failed++;
      $display("FAIL accept_timeout actual=in_ready_low expected=accept rd=%0d", rd);
    end else begin
      e.res  = exp_res;
      e.rd   = rd;
      e.wreg = wreg & ~exp_ovf;
      e.ovf  = exp_ovf;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_aluc   = 5'd0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_rd     = 5'd0;
    bus.in_wreg   = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #22 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("rst_result",    bus.out_result, 32'd0);
    chk("rst_zero",      {31'd0, bus.out_zero}, 32'd1);
    @(posedge clk);
    #1;

    // Full-throughput stream of every opcode class.
    send(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd1,  1'b1, 32'h80000000, 1'b1);
    send(ALU_ADDU, 32'h7FFFFFFF, 32'h00000001, 5'd2,  1'b1, 32'h80000000, 1'b0);
    send(ALU_ADD,  32'h00000001, 32'h00000001, 5'd3,  1'b1, 32'h00000002, 1'b0);
    send(ALU_SUB,  32'h80000000, 32'h00000001, 5'd4,  1'b1, 32'h7FFFFFFF, 1'b1);
    send(ALU_SUBU, 32'h00000005, 32'h00000005, 5'd5,  1'b1, 32'h00000000, 1'b0);
    send(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd6,  1'b0, 32'hF000F000, 1'b0);
    send(ALU_OR,   32'h0F0F0000, 32'h000000F0, 5'd7,  1'b1, 32'h0F0F00F0, 1'b0);
    send(ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 5'd8,  1'b1, 32'hF0F00F0F, 1'b0);
    send(ALU_NOR,  32'h00000000, 32'h00000000, 5'd9,  1'b1, 32'hFFFFFFFF, 1'b0);
    send(ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd10, 1'b1, 32'h00000001, 1'b0);
    send(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd11, 1'b1, 32'h00000000, 1'b0);
    send(ALU_SLL,  32'h00000004, 32'h80000001, 5'd12, 1'b1, 32'h00000010, 1'b0);
    send(ALU_SRL,  32'h00000004, 32'h80000001, 5'd13, 1'b1, 32'h08000000, 1'b0);
    send(ALU_SRA,  32'h00000004, 32'h80000001, 5'd14, 1'b1, 32'hF8000000, 1'b0);
    send(ALU_SLC,  32'h00000004, 32'h80000001, 5'd15, 1'b1, 32'h00000018, 1'b0);
    send(ALU_LUI,  32'h00000000, 32'h00001234, 5'd16, 1'b1, 32'h12340000, 1'b0);
    send(5'd20,    32'h00000005, 32'h00000006, 5'd17, 1'b1, 32'h00000000, 1'b0);
    drain();

    // Stall: M and S fill, in_ready drops, outputs hold, order preserved.
    bus.out_ready = 1'b0;
    send(ALU_ADDU, 32'd1, 32'd2, 5'd21, 1'b1, 32'h00000003, 1'b0);
    send(ALU_OR,   32'd4, 32'd8, 5'd22, 1'b1, 32'h0000000C, 1'b0);
    @(negedge clk);
    chk("stall_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("stall_result_0",  bus.out_result, 32'h00000003);
    @(negedge clk);
    chk("stall_result_1",  bus.out_result, 32'h00000003);
    @(posedge clk);
    #1;
    fork
      begin
        send(ALU_XOR, 32'h000000FF, 32'h0000000F, 5'd23, 1'b1, 32'h000000F0, 1'b0);
        send(ALU_SLL, 32'd8,        32'h00000001, 5'd24, 1'b1, 32'h00000100, 1'b0);
      end
      begin
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Flush with M and S full and a new op offered: all three vanish.
    bus.out_ready = 1'b0;
    send(ALU_ADDU, 32'd10, 32'd1, 5'd25, 1'b1, 32'd11, 1'b0);
    send(ALU_ADDU, 32'd20, 32'd1, 5'd26, 1'b1, 32'd21, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_aluc  = ALU_ADDU;
    bus.in_a     = 32'd30;
    bus.in_b     = 32'd1;
    bus.in_rd    = 5'd27;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    send(ALU_SUBU, 32'd9, 32'd4, 5'd28, 1'b1, 32'd5, 1'b0);
    drain();

    // Asynchronous reset while M holds a valid entry.
    bus.out_ready = 1'b0;
    send(ALU_ADDU, 32'h12345678, 32'h11111111, 5'd29, 1'b1, 32'h23456789, 1'b0);
    @(negedge clk);
    chk("pre_arst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_result",    bus.out_result, 32'd0);
    chk("arst_rd",        {27'd0, bus.out_rd}, 32'd0);
    chk("arst_wreg",      {31'd0, bus.out_wreg}, 32'd0);
    chk("arst_ovf",       {31'd0, bus.out_ovf}, 32'd0);
    chk("arst_zero",      {31'd0, bus.out_zero}, 32'd1);
    chk("arst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    sb.delete();
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(ALU_AND, 32'hFFFF0000, 32'h0F0F0F0F, 5'd30, 1'b1, 32'h0F0F0000, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
